// File: rtl/prbs_checker.sv
// Self-synchronising checker for the Galois-LFSR randomizer stream: locks onto
// the incoming sequence, then free-runs its own prediction and counts mismatches.
//
// state  | meaning
// SEARCH | looking for LOCK_COUNT consecutive words that follow nxt() of the previous word
// LOCKED | predicting every valid word; UNLOCK_COUNT consecutive misses return to SEARCH
module prbs_checker #(
    parameter int                     INPUT_WIDTH  = 32,
    parameter logic [INPUT_WIDTH-1:0] LFSR_TAP     = INPUT_WIDTH'(32'h8020_0003),
    parameter int                     LOCK_COUNT   = 4,
    parameter int                     UNLOCK_COUNT = 8,
    parameter int                     COUNT_WIDTH  = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [INPUT_WIDTH-1:0] data_in,
    input  logic                   data_in_valid,
    input  logic                   clear,
    output logic                   locked,
    output logic                   error,
    output logic [COUNT_WIDTH-1:0] error_count
);

    if (INPUT_WIDTH < 3 || LFSR_TAP[INPUT_WIDTH-1] != 1'b1) begin : g_bad_lfsr
        $fatal(1, "prbs_checker: INPUT_WIDTH must be >= 3 and LFSR_TAP must have its top bit set");
    end
    if (LOCK_COUNT < 1 || LOCK_COUNT > 255 || UNLOCK_COUNT < 1 || UNLOCK_COUNT > 255) begin : g_bad_counts
        $fatal(1, "prbs_checker: LOCK_COUNT and UNLOCK_COUNT must be in 1..255");
    end

    localparam logic [0:0] SEARCH = 1'b0;
    localparam logic [0:0] LOCKED = 1'b1;

    localparam logic [7:0] LOCK_MATCHES = 8'(LOCK_COUNT);
    localparam logic [7:0] UNLOCK_MISSES = 8'(UNLOCK_COUNT);

    // The all-ones word maps to zero, mirroring the generator's lock-up escape.
    function automatic logic [INPUT_WIDTH-1:0] nxt(input logic [INPUT_WIDTH-1:0] s);
        logic [INPUT_WIDTH-1:0] n;
        if (&s) begin
            n = '0;
        end else begin
            n[INPUT_WIDTH-1] = s[0];
            for (int i = 0; i < INPUT_WIDTH - 1; i++) begin
                n[i] = LFSR_TAP[i] ? ~(s[i+1] ^ s[0]) : s[i+1];
            end
        end
        return n;
    endfunction

    logic [0:0]             state;
    logic [INPUT_WIDTH-1:0] prev;       // last word in SEARCH, predicted word in LOCKED
    logic                   have_prev;
    logic [7:0]             match_cnt;
    logic [7:0]             bad_cnt;
    logic [7:0]             match_inc;
    logic [7:0]             bad_inc;

    assign match_inc = match_cnt + 8'd1;
    assign bad_inc   = bad_cnt + 8'd1;
    assign locked    = (state == LOCKED);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= SEARCH;
            prev        <= '0;
            have_prev   <= 1'b0;
            match_cnt   <= 8'd0;
            bad_cnt     <= 8'd0;
            error       <= 1'b0;
            error_count <= '0;
        end else begin
            error <= 1'b0;
            if (data_in_valid) begin
                if (state == SEARCH) begin
                    have_prev <= 1'b1;
                    if (have_prev && data_in == nxt(prev)) begin
                        match_cnt <= match_inc;
                        if (match_inc == LOCK_MATCHES) begin
                            state   <= LOCKED;
                            bad_cnt <= 8'd0;
                            prev    <= nxt(data_in);
                        end else begin
                            prev <= data_in;
                        end
                    end else begin
                        match_cnt <= 8'd0;
                        prev      <= data_in;
                    end
                end else begin
                    prev <= nxt(prev);
                    if (data_in != prev) begin
                        error   <= 1'b1;
                        bad_cnt <= bad_inc;
                        if (error_count != '1) begin
                            error_count <= error_count + COUNT_WIDTH'(1);
                        end
                        if (bad_inc == UNLOCK_MISSES) begin
                            state     <= SEARCH;
                            prev      <= data_in;
                            have_prev <= 1'b1;
                            match_cnt <= 8'd0;
                        end
                    end else begin
                        bad_cnt <= 8'd0;
                    end
                end
            end
            // Clear wins over a same-cycle mismatch; the error pulse is unaffected.
            if (clear) begin
                error_count <= '0;
            end
        end
    end

endmodule

// File: tb/tb_prbs_checker.sv
// Directed bench for prbs_checker: a sequence-level reference model checked every
// cycle, plus literal expectations at the lock, error, unlock and reset points.
module tb_prbs_checker;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] data_in = 32'h0;
    logic        data_in_valid = 1'b0;
    logic        clear = 1'b0;
    logic        locked, error, locked4, error4;
    logic [15:0] cnt16;
    logic [3:0]  cnt4;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    prbs_checker dut (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .data_in_valid(data_in_valid),
        .clear(clear), .locked(locked), .error(error), .error_count(cnt16)
    );

    prbs_checker #(.COUNT_WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .data_in_valid(data_in_valid),
        .clear(clear), .locked(locked4), .error(error4), .error_count(cnt4)
    );

    localparam logic [31:0] TAP_LOW = 32'h0020_0003;

    // Galois step as a rotate plus conditional XOR of the (inverting) low taps.
    function automatic logic [31:0] ref_nxt(input logic [31:0] s);
        if (s == 32'hFFFF_FFFF) return 32'h0;
        return {s[0], s[31:1]} ^ (s[0] ? TAP_LOW : 32'h0) ^ TAP_LOW;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: length of the current nxt() chain while hunting, free-running prediction once locked.
    bit          m_locked = 1'b0;
    bit          m_err = 1'b0;
    int          m_cnt = 0;
    int          m_chain = 0;
    int          m_miss = 0;
    logic [31:0] m_last = 32'h0;
    logic [31:0] m_pred = 32'h0;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_locked = 1'b0; m_err = 1'b0; m_cnt = 0; m_chain = 0; m_miss = 0;
        end else begin
            m_err = 1'b0;
            if (data_in_valid) begin
                if (!m_locked) begin
                    if (m_chain > 0 && data_in == ref_nxt(m_last)) m_chain++;
                    else m_chain = 1;
                    m_last = data_in;
                    if (m_chain == 4 + 1) begin
                        m_locked = 1'b1;
                        m_pred = ref_nxt(data_in);
                        m_miss = 0;
                    end
                end else begin
                    if (data_in != m_pred) begin
                        m_err = 1'b1;
                        m_cnt++;
                        m_miss++;
                        if (m_miss == 8) begin
                            m_locked = 1'b0;
                            m_chain = 1;
                            m_last = data_in;
                        end
                    end else begin
                        m_miss = 0;
                    end
                    m_pred = ref_nxt(m_pred);
                end
            end
            if (clear) m_cnt = 0;
        end
    end

    initial forever begin
        @(negedge clk);
        chk("locked", 32'(locked), 32'(m_locked));
        chk("error", 32'(error), 32'(m_err));
        chk("count16", 32'(cnt16), (m_cnt > 65535) ? 32'd65535 : 32'(m_cnt));
        chk("locked4", 32'(locked4), 32'(m_locked));
        chk("error4", 32'(error4), 32'(m_err));
        chk("count4", 32'(cnt4), (m_cnt > 15) ? 32'd15 : 32'(m_cnt));
    end

    logic [31:0] g;

    task automatic drive(input logic [31:0] d, input bit v, input bit c);
        data_in = d;
        data_in_valid = v;
        clear = c;
        @(posedge clk);
        #2;
        data_in_valid = 1'b0;
        clear = 1'b0;
    endtask

    task automatic good();
        g = ref_nxt(g);
        drive(g, 1'b1, 1'b0);
    endtask

    initial begin
        chk("nxt_zero", ref_nxt(32'h0), 32'h0020_0003);
        chk("nxt_second", ref_nxt(32'h0020_0003), 32'h8010_0001);
        chk("nxt_ones", ref_nxt(32'hFFFF_FFFF), 32'h0);

        repeat (2) @(posedge clk);
        #2;
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_count", 32'(cnt16), 32'd0);
        rst_n = 1'b1;

        // lock from reset
        g = 32'h0;          drive(g, 1'b1, 1'b0); chk("lock_w1", 32'(locked), 32'd0);
        g = 32'h0020_0003;  drive(g, 1'b1, 1'b0); chk("lock_w2", 32'(locked), 32'd0);
        g = 32'h8010_0001;  drive(g, 1'b1, 1'b0); chk("lock_w3", 32'(locked), 32'd0);
        good(); chk("lock_w4", 32'(locked), 32'd0);
        good(); chk("lock_w5", 32'(locked), 32'd1);
        chk("lock_count", 32'(cnt16), 32'd0);

        // long loopback
        repeat (10000) good();
        chk("loop_count", 32'(cnt16), 32'd0);
        chk("loop_locked", 32'(locked), 32'd1);

        // single flipped bit
        g = ref_nxt(g);
        drive(g ^ 32'h80, 1'b1, 1'b0);
        chk("flip_error", 32'(error), 32'd1);
        chk("flip_count", 32'(cnt16), 32'd1);
        chk("flip_locked", 32'(locked), 32'd1);
        repeat (5) good();
        chk("flip_after", 32'(cnt16), 32'd1);

        // loss of lock and relock
        drive(32'h0, 1'b0, 1'b1);
        chk("clear_idle", 32'(cnt16), 32'd0);
        for (int i = 0; i < 8; i++) begin
            drive($urandom(), 1'b1, 1'b0);
            if (i == 6) chk("unlock_7th", 32'(locked), 32'd1);
        end
        chk("unlock_8th", 32'(locked), 32'd0);
        chk("unlock_count", 32'(cnt16), 32'd8);
        chk("unlock_error", 32'(error), 32'd1);
        for (int i = 0; i < 5; i++) begin
            good();
            if (i == 3) chk("relock_early", 32'(locked), 32'd0);
        end
        chk("relock", 32'(locked), 32'd1);

        // gaps between words
        repeat (40) begin
            repeat ($urandom_range(0, 2)) drive(32'hDEAD_BEEF, 1'b0, 1'b0);
            good();
        end
        chk("gap_locked", 32'(locked), 32'd1);
        chk("gap_count", 32'(cnt16), 32'd8);

        // clear together with a mismatch
        g = ref_nxt(g);
        drive(g ^ 32'h1, 1'b1, 1'b1);
        chk("clr_error", 32'(error), 32'd1);
        chk("clr_count", 32'(cnt16), 32'd0);
        good();
        chk("clr_next", 32'(error), 32'd0);

        // saturation on the narrow counter
        repeat (20) begin
            g = ref_nxt(g);
            drive(g ^ 32'h8000_0000, 1'b1, 1'b0);
            good();
        end
        chk("sat_count4", 32'(cnt4), 32'd15);
        chk("sat_count16", 32'(cnt16), 32'd20);
        chk("sat_locked", 32'(locked), 32'd1);

        // asynchronous reset mid-stream with error high
        g = ref_nxt(g);
        drive(g ^ 32'h10, 1'b1, 1'b0);
        chk("pre_rst_error", 32'(error), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_locked", 32'(locked), 32'd0);
        chk("arst_error", 32'(error), 32'd0);
        chk("arst_count16", 32'(cnt16), 32'd0);
        chk("arst_count4", 32'(cnt4), 32'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;

        // partial lock discarded by reset
        g = 32'h1234_5678;
        drive(g, 1'b1, 1'b0);
        good();
        good();
        #1 rst_n = 1'b0;
        #1 rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            good();
            if (i == 3) chk("partial_w4", 32'(locked), 32'd0);
        end
        chk("partial_w5", 32'(locked), 32'd1);
        repeat (3) good();
        chk("final_count", 32'(cnt16), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
